spi_master_arbiter: RTL and testbench

//  Round-robin arbiter/sequencer sharing one SPI master (spi_module, SPI_MASTER=1) among N requesters.

---
 rtl/spi_pkg.sv | 32 +++
 rtl/rr_picker.sv | 29 ++
 rtl/spi_master_arbiter.sv | 168 ++++++++++++++++
 tb/tb_spi_master_arbiter.sv | 400 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/spi_pkg.sv
// Shared types and frame layout for the SPI master arbiter.
// Frame is {rw, addr, wait, data} with data in the low bits.
package spi_pkg;

  localparam int ADDR_LEN_DEF = 8;
  localparam int WAIT_LEN_DEF = 2;
  localparam int WORD_LEN_DEF = 16;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_LAUNCH,
    ST_BUSY,
    ST_DONE
  } state_t;

  function automatic int frame_len(input int addr_len, input int wait_len, input int word_len);
    return 1 + addr_len + wait_len + word_len;
  endfunction

  function automatic int wait_lsb(input int word_len);
    return word_len;
  endfunction

  function automatic int addr_lsb(input int wait_len, input int word_len);
    return wait_len + word_len;
  endfunction

  function automatic int rw_bit(input int addr_len, input int wait_len, input int word_len);
    return addr_len + wait_len + word_len;
  endfunction

endpackage

// File: rtl/rr_picker.sv
// Combinational round-robin search: first set request at or after i_ptr, wrapping.
// No state; o_vld low when no request is set.
module rr_picker #(
  parameter int N_REQ = 4,
  parameter int IDXW  = 2
) (
  input  logic [N_REQ-1:0] i_req,
  input  logic [IDXW-1:0]  i_ptr,
  output logic [IDXW-1:0]  o_idx,
  output logic             o_vld
);

  always_comb begin : p_search
    int v_k;
    o_idx = '0;
    o_vld = 1'b0;
    v_k   = 0;
    // Walk from the farthest offset down so the nearest request wins last.
    for (int i = N_REQ - 1; i >= 0; i--) begin
      v_k = int'(i_ptr) + i;
      if (v_k >= N_REQ) v_k = v_k - N_REQ;
      if (i_req[v_k]) begin
        o_idx = IDXW'(v_k);
        o_vld = 1'b1;
      end
    end
  end

endmodule

// File: rtl/spi_master_arbiter.sv
// Round-robin sequencer sharing one SPI master among N_REQ register clients.
// Grants one request, launches its frame, waits for completion and acks with read data.
module spi_master_arbiter
  import spi_pkg::*;
#(
  parameter int N_REQ    = 4,
  parameter int ADDR_LEN = ADDR_LEN_DEF,
  parameter int WAIT_LEN = WAIT_LEN_DEF,
  parameter int WORD_LEN = WORD_LEN_DEF,
  parameter int TIMEOUT  = 1023,
  localparam int FRAME_LEN = frame_len(ADDR_LEN, WAIT_LEN, WORD_LEN)
) (
  input  logic                      i_master_clock,
  input  logic                      i_rst,
  input  logic [N_REQ-1:0]          i_req,
  input  logic [N_REQ-1:0]          i_req_rw,
  input  logic [N_REQ*ADDR_LEN-1:0] i_req_addr,
  input  logic [N_REQ*WORD_LEN-1:0] i_req_wdata,
  output logic [N_REQ-1:0]          o_ack,
  output logic [WORD_LEN-1:0]       o_rdata,
  output logic                      o_err,
  output logic                      o_busy,
  input  logic                      i_spi_ready,
  input  logic                      i_spi_processing,
  output logic                      o_spi_next_word,
  output logic [FRAME_LEN-1:0]      o_spi_word_send,
  input  logic [FRAME_LEN-1:0]      i_spi_word_recv
);

  localparam int IDXW     = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int RW_BIT   = rw_bit(ADDR_LEN, WAIT_LEN, WORD_LEN);
  localparam int ADDR_LSB = addr_lsb(WAIT_LEN, WORD_LEN);
  localparam logic [9:0] TMO = 10'(TIMEOUT);

  state_t               r_state;
  state_t               w_state_nxt;
  logic [IDXW-1:0]      r_ptr;
  logic [IDXW-1:0]      r_grant;
  logic                 r_rw;
  logic [FRAME_LEN-1:0] r_frame;
  logic [9:0]           r_timer;
  logic [N_REQ-1:0]     r_ack;
  logic [WORD_LEN-1:0]  r_rdata;
  logic                 r_err;
  logic                 r_busy;
  logic                 r_next_word;

  logic [IDXW-1:0]      w_pick_idx;
  logic                 w_pick_vld;
  logic [FRAME_LEN-1:0] w_frame;
  logic                 w_tmo;
  logic                 w_grant;
  logic                 w_done_ok;
  logic                 w_done_err;
  logic                 w_unused_recv;

  rr_picker #(
    .N_REQ (N_REQ),
    .IDXW  (IDXW)
  ) u_rr_picker (
    .i_req (i_req),
    .i_ptr (r_ptr),
    .o_idx (w_pick_idx),
    .o_vld (w_pick_vld)
  );

  assign w_tmo         = (r_timer == TMO);
  assign w_unused_recv = ^i_spi_word_recv[FRAME_LEN-1:WORD_LEN];

  always_comb begin
    w_frame = '0;
    w_frame[RW_BIT] = i_req_rw[w_pick_idx];
    w_frame[ADDR_LSB +: ADDR_LEN] = i_req_addr[int'(w_pick_idx)*ADDR_LEN +: ADDR_LEN];
    w_frame[0 +: WORD_LEN] = i_req_wdata[int'(w_pick_idx)*WORD_LEN +: WORD_LEN];
  end

  always_ff @(posedge i_master_clock) begin
    if (i_rst) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_grant     = 1'b0;
    w_done_ok   = 1'b0;
    w_done_err  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (i_spi_ready && w_pick_vld) begin
          w_grant     = 1'b1;
          w_state_nxt = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        if (i_spi_processing) begin
          w_state_nxt = ST_BUSY;
        end else if (w_tmo) begin
          w_done_err  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_BUSY: begin
        if (!i_spi_processing) begin
          w_done_ok   = 1'b1;
          w_state_nxt = ST_DONE;
        end else if (w_tmo) begin
          w_done_err  = 1'b1;
          w_state_nxt = ST_DONE;
        end
      end
      ST_DONE:  w_state_nxt = ST_IDLE;
      default:  w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge i_master_clock) begin
    if (i_rst) begin
      r_ptr       <= '0;
      r_grant     <= '0;
      r_rw        <= 1'b0;
      r_frame     <= '0;
      r_timer     <= '0;
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= 1'b0;
      r_next_word <= 1'b0;
    end else begin
      r_ack       <= '0;
      r_rdata     <= '0;
      r_err       <= 1'b0;
      r_busy      <= (w_state_nxt != ST_IDLE);
      r_next_word <= (w_state_nxt == ST_LAUNCH);

      // Timer restarts on every state change and only runs while waiting on the master.
      if (w_state_nxt != r_state) begin
        r_timer <= '0;
      end else if (r_state == ST_LAUNCH || r_state == ST_BUSY) begin
        r_timer <= r_timer + 10'd1;
      end

      if (w_grant) begin
        r_grant <= w_pick_idx;
        r_rw    <= i_req_rw[w_pick_idx];
        r_frame <= w_frame;
      end

      // Ack is registered on entry to DONE so it is visible for exactly the DONE cycle.
      if (w_done_ok || w_done_err) begin
        r_ack[r_grant] <= 1'b1;
        r_err          <= w_done_err;
        r_rdata        <= (w_done_ok && r_rw) ? i_spi_word_recv[WORD_LEN-1:0] : '0;
      end

      if (r_state == ST_DONE) begin
        r_ptr <= (r_grant == IDXW'(N_REQ - 1)) ? '0 : r_grant + 1'b1;
      end
    end
  end

  assign o_ack           = r_ack;
  assign o_rdata         = r_rdata;
  assign o_err           = r_err;
  assign o_busy          = r_busy;
  assign o_spi_next_word = r_next_word;
  assign o_spi_word_send = r_frame;

endmodule

// File: tb/tb_spi_master_arbiter.sv
// Bench for spi_master_arbiter with a behavioural SPI master/slave model and
// a round-robin reference model of grant order and slave memory contents.
module tb_spi_master_arbiter;

  localparam int N   = 4;
  localparam int AL  = 8;
  localparam int WL  = 2;
  localparam int DL  = 16;
  localparam int TMO = 1023;
  localparam int FL  = 1 + AL + WL + DL;

  logic            clk = 1'b0;
  logic            rst = 1'b1;
  logic [N-1:0]    req = '0;
  logic [N-1:0]    req_rw = '0;
  logic [N*AL-1:0] req_addr = '0;
  logic [N*DL-1:0] req_wdata = '0;
  logic [N-1:0]    ack;
  logic [DL-1:0]   rdata;
  logic            err;
  logic            busy;
  logic            spi_ready = 1'b1;
  logic            spi_proc = 1'b0;
  logic            next_word;
  logic [FL-1:0]   word_send;
  logic [FL-1:0]   spi_recv = '0;

  always #5 clk = ~clk;

  spi_master_arbiter dut (
    .i_master_clock   (clk),
    .i_rst            (rst),
    .i_req            (req),
    .i_req_rw         (req_rw),
    .i_req_addr       (req_addr),
    .i_req_wdata      (req_wdata),
    .o_ack            (ack),
    .o_rdata          (rdata),
    .o_err            (err),
    .o_busy           (busy),
    .i_spi_ready      (spi_ready),
    .i_spi_processing (spi_proc),
    .o_spi_next_word  (next_word),
    .o_spi_word_send  (word_send),
    .i_spi_word_recv  (spi_recv)
  );

  typedef struct {
    logic [N-1:0]  ack;
    logic [DL-1:0] rdata;
    logic          err;
  } ack_rec_t;

  int            checks = 0;
  int            errors = 0;
  logic [DL-1:0] slv_mem [256];
  logic [DL-1:0] ref_mem [256];
  int            ref_ptr = 0;
  ack_rec_t      ack_q [$];
  logic [FL-1:0] frame_q [$];
  bit            spi_stall = 1'b0;
  int            hold_cnt = 0;
  bit            drop_all = 1'b0;
  logic          e_rw [N];
  logic [AL-1:0] e_addr [N];
  logic [DL-1:0] e_wd [N];

  // SPI master + slave environment: takes a frame, runs it, returns slave data.
  initial begin : spi_env
    logic [FL-1:0] f;
    logic [AL-1:0] a;
    logic [DL-1:0] rd;
    forever begin
      @(posedge clk); #1;
      if (!rst && !spi_stall && next_word && spi_ready) begin
        f = word_send;
        frame_q.push_back(f);
        spi_ready = 1'b0;
        repeat ($urandom_range(0, 2)) @(posedge clk);
        #1 spi_proc = 1'b1;
        a  = f[DL+WL +: AL];
        rd = slv_mem[a];
        if (!f[FL-1]) slv_mem[a] = f[DL-1:0];
        repeat ($urandom_range(2, 6)) @(posedge clk);
        #1;
        spi_recv[FL-1:DL] = 11'($urandom());
        spi_recv[DL-1:0]  = f[FL-1] ? rd : 16'($urandom());
        spi_proc = 1'b0;
        @(posedge clk); #1 spi_ready = 1'b1;
      end
    end
  end

  // Ack monitor: records every ack and releases requesters like real clients would.
  initial begin : ack_mon
    forever begin
      @(negedge clk);
      if (ack != '0) begin
        ack_q.push_back(ack_rec_t'{ack, rdata, err});
        if (hold_cnt > 0) hold_cnt--;
        else if (drop_all) req = '0;
        else req = req & ~ack;
      end
    end
  end

  function automatic int oh_idx(input logic [N-1:0] v);
    int r;
    r = -1;
    if ($countones(v) != 1) return -2;
    for (int i = 0; i < N; i++) if (v[i]) r = i;
    return r;
  endfunction

  function automatic int model_pick(input logic [N-1:0] m);
    for (int i = 0; i < N; i++) if (m[(ref_ptr + i) % N]) return (ref_ptr + i) % N;
    return -1;
  endfunction

  task automatic set_req(input int k, input logic rw, input logic [AL-1:0] a, input logic [DL-1:0] d);
    e_rw[k] = rw; e_addr[k] = a; e_wd[k] = d;
    req_rw[k] = rw;
    req_addr[k*AL +: AL] = a;
    req_wdata[k*DL +: DL] = d;
    req[k] = 1'b1;
  endtask

  task automatic wait_ack(output bit ok, output ack_rec_t r);
    int c;
    c = 0;
    r = ack_rec_t'{'0, '0, 1'b0};
    while (ack_q.size() == 0 && c < 3000) begin
      @(posedge clk);
      c++;
    end
    ok = (ack_q.size() > 0);
    if (ok) r = ack_q.pop_front();
  endtask

  task automatic pop_frame(output logic [FL-1:0] f);
    if (frame_q.size() > 0) f = frame_q.pop_front();
    else f = 'x;
  endtask

  task automatic do_reset();
    int c;
    c = 0;
    while (!spi_ready && c < 100) begin @(negedge clk); c++; end
    @(negedge clk); #1;
    req = '0; rst = 1'b1;
    @(negedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    ack_q.delete();
    frame_q.delete();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    checks++; if (ack !== '0) begin errors++; $display("FAIL reset_ack: got %b want 0", ack); end
    checks++; if (rdata !== '0) begin errors++; $display("FAIL reset_rdata: got %h want 0", rdata); end
    checks++; if (err !== 1'b0) begin errors++; $display("FAIL reset_err: got %b want 0", err); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (next_word !== 1'b0) begin errors++; $display("FAIL reset_next_word: got %b want 0", next_word); end
    checks++; if (word_send !== '0) begin errors++; $display("FAIL reset_word_send: got %h want 0", word_send); end
    #1 rst = 1'b0;
    ref_ptr = 0;
  endtask

  task automatic test_single_write();
    bit ok; ack_rec_t r; logic [FL-1:0] f;
    @(negedge clk); #1;
    set_req(0, 1'b0, 8'h84, 16'h0001);
    wait_ack(ok, r);
    pop_frame(f);
    checks++;
    if (!ok || oh_idx(r.ack) !== 0 || f !== {1'b0, 8'h84, 2'b00, 16'h0001} || r.err !== 1'b0 || r.rdata !== 16'h0) begin
      errors++;
      $display("FAIL single_write: ok=%0d ack=%b frame=%h err=%b rdata=%h, want ack[0] frame=%h err=0 rdata=0",
               ok, r.ack, f, r.err, r.rdata, {1'b0, 8'h84, 2'b00, 16'h0001});
    end
    ref_ptr = 1;
    ref_mem[8'h84] = 16'h0001;
  endtask

  task automatic test_single_read();
    bit ok; ack_rec_t r; logic [FL-1:0] f;
    slv_mem[8'h1F] = 16'hFFF3;
    ref_mem[8'h1F] = 16'hFFF3;
    @(negedge clk); #1;
    set_req(1, 1'b1, 8'h1F, 16'h5A5A);
    wait_ack(ok, r);
    pop_frame(f);
    checks++;
    if (!ok || oh_idx(r.ack) !== 1 || f !== {1'b1, 8'h1F, 2'b00, 16'h5A5A} || r.err !== 1'b0 || r.rdata !== 16'hFFF3) begin
      errors++;
      $display("FAIL single_read: ok=%0d ack=%b frame=%h err=%b rdata=%h, want ack[1] rdata=fff3 err=0",
               ok, r.ack, f, r.err, r.rdata);
    end
    ref_ptr = 2;
  endtask

  task automatic test_contention();
    bit ok; ack_rec_t r; logic [FL-1:0] f; int k;
    logic [FL-1:0] exp_f; logic [DL-1:0] exp_rd;
    do_reset();
    for (int i = 0; i < N; i++)
      set_req(i, 1'($urandom()), 8'($urandom_range(0, 7)), 16'($urandom()));
    hold_cnt = 4;
    drop_all = 1'b1;
    for (int n = 0; n < 5; n++) begin
      wait_ack(ok, r);
      pop_frame(f);
      k = model_pick(4'b1111);
      exp_f  = {e_rw[k], e_addr[k], 2'b00, e_wd[k]};
      exp_rd = e_rw[k] ? ref_mem[e_addr[k]] : '0;
      checks++;
      if (!ok || oh_idx(r.ack) !== k || f !== exp_f || r.err !== 1'b0 || r.rdata !== exp_rd) begin
        errors++;
        $display("FAIL contention[%0d]: ok=%0d ack=%b frame=%h rdata=%h err=%b, want idx=%0d frame=%h rdata=%h",
                 n, ok, r.ack, f, r.rdata, r.err, k, exp_f, exp_rd);
      end
      ref_ptr = (k + 1) % N;
      if (!e_rw[k]) ref_mem[e_addr[k]] = e_wd[k];
    end
    repeat (30) @(negedge clk);
    drop_all = 1'b0;
    checks++;
    if (ack_q.size() != 0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL contention_idle: extra acks=%0d busy=%b, want 0 and 0", ack_q.size(), busy);
    end
  endtask

  task automatic test_fairness();
    bit ok; ack_rec_t r; logic [FL-1:0] f; int k;
    logic [FL-1:0] exp_f; logic [DL-1:0] exp_rd; logic [N-1:0] pend;
    do_reset();
    set_req(2, 1'b0, 8'h30, 16'hBEEF);
    wait_ack(ok, r);
    pop_frame(f);
    checks++;
    if (!ok || oh_idx(r.ack) !== 2) begin
      errors++; $display("FAIL fairness_first: ok=%0d ack=%b, want ack[2]", ok, r.ack);
    end
    ref_ptr = 3;
    ref_mem[8'h30] = 16'hBEEF;
    @(negedge clk); #1;
    set_req(0, 1'b1, 8'h30, 16'h1111);
    set_req(2, 1'b1, 8'h84, 16'h2222);
    pend = 4'b0101;
    for (int n = 0; n < 2; n++) begin
      wait_ack(ok, r);
      pop_frame(f);
      k = model_pick(pend);
      exp_f  = {e_rw[k], e_addr[k], 2'b00, e_wd[k]};
      exp_rd = ref_mem[e_addr[k]];
      checks++;
      if (!ok || oh_idx(r.ack) !== k || f !== exp_f || r.err !== 1'b0 || r.rdata !== exp_rd) begin
        errors++;
        $display("FAIL fairness[%0d]: ok=%0d ack=%b frame=%h rdata=%h, want idx=%0d frame=%h rdata=%h",
                 n, ok, r.ack, f, r.rdata, k, exp_f, exp_rd);
      end
      ref_ptr = (k + 1) % N;
      pend[k] = 1'b0;
    end
  endtask

  task automatic test_random();
    bit ok; ack_rec_t r; logic [FL-1:0] f; int k;
    logic [FL-1:0] exp_f; logic [DL-1:0] exp_rd; logic [N-1:0] pend;
    for (int round = 0; round < 8; round++) begin
      repeat ($urandom_range(1, 4)) @(negedge clk);
      #1;
      pend = 4'($urandom_range(1, 15));
      for (int i = 0; i < N; i++)
        if (pend[i]) set_req(i, 1'($urandom()), 8'($urandom_range(0, 5)), 16'($urandom()));
      while (pend != '0) begin
        wait_ack(ok, r);
        pop_frame(f);
        k = model_pick(pend);
        exp_f  = {e_rw[k], e_addr[k], 2'b00, e_wd[k]};
        exp_rd = e_rw[k] ? ref_mem[e_addr[k]] : '0;
        checks++;
        if (!ok || oh_idx(r.ack) !== k || f !== exp_f || r.err !== 1'b0 || r.rdata !== exp_rd) begin
          errors++;
          $display("FAIL random[%0d]: ok=%0d ack=%b frame=%h rdata=%h err=%b, want idx=%0d frame=%h rdata=%h",
                   round, ok, r.ack, f, r.rdata, r.err, k, exp_f, exp_rd);
        end
        ref_ptr = (k + 1) % N;
        if (!e_rw[k]) ref_mem[e_addr[k]] = e_wd[k];
        pend[k] = 1'b0;
        if (!ok) pend = '0;
      end
    end
  endtask

  task automatic test_timeout();
    bit ok; ack_rec_t r; int cyc; int c; bit seen;
    spi_stall = 1'b1;
    @(negedge clk); #1;
    set_req(3, 1'b1, 8'h1F, 16'h0);
    c = 0;
    seen = 1'b0;
    while (!seen && c < 20) begin @(negedge clk); seen = next_word; c++; end
    cyc = 0;
    while (seen && cyc < 2000) begin
      @(posedge clk); cyc++;
      @(negedge clk);
      if (ack != '0) break;
    end
    checks++;
    if (!seen || cyc != TMO + 1) begin
      errors++; $display("FAIL timeout_latency: launched=%0d cycles=%0d, want %0d", seen, cyc, TMO + 1);
    end
    checks++;
    if (next_word !== 1'b0) begin
      errors++; $display("FAIL timeout_next_word: got %b at ack, want 0", next_word);
    end
    wait_ack(ok, r);
    checks++;
    if (!ok || oh_idx(r.ack) !== 3 || r.err !== 1'b1 || r.rdata !== '0) begin
      errors++; $display("FAIL timeout_ack: ok=%0d ack=%b err=%b rdata=%h, want ack[3] err=1 rdata=0", ok, r.ack, r.err, r.rdata);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0) begin
      errors++; $display("FAIL timeout_idle: busy=%b, want 0", busy);
    end
    ref_ptr = 0;
    spi_stall = 1'b0;
  endtask

  task automatic test_reset_mid_busy();
    bit ok; ack_rec_t r; logic [FL-1:0] f; int c; bit bad; logic [DL-1:0] exp_rd;
    @(negedge clk); #1;
    set_req(1, 1'b1, 8'h84, 16'h7777);
    c = 0;
    while (!(busy && spi_proc) && c < 100) begin @(negedge clk); c++; end
    #1 rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (ack !== '0 || busy !== 1'b0 || next_word !== 1'b0 || word_send !== '0 || err !== 1'b0) begin
      errors++;
      $display("FAIL mid_busy_reset: ack=%b busy=%b next_word=%b send=%h err=%b, want all 0", ack, busy, next_word, word_send, err);
    end
    @(negedge clk); #1;
    rst = 1'b0;
    ref_ptr = 0;
    frame_q.delete();
    bad = 1'b0;
    c = 0;
    while (!spi_ready && c < 50) begin
      @(negedge clk);
      if (!spi_ready && next_word) bad = 1'b1;
      c++;
    end
    checks++;
    if (bad || ack_q.size() != 0) begin
      errors++; $display("FAIL mid_busy_quiet: launch_while_not_ready=%0d acks=%0d, want 0 and 0", bad, ack_q.size());
    end
    exp_rd = ref_mem[8'h84];
    wait_ack(ok, r);
    pop_frame(f);
    checks++;
    if (!ok || oh_idx(r.ack) !== 1 || f !== {1'b1, 8'h84, 2'b00, 16'h7777} || r.err !== 1'b0 || r.rdata !== exp_rd) begin
      errors++;
      $display("FAIL mid_busy_retry: ok=%0d ack=%b frame=%h rdata=%h err=%b, want ack[1] rdata=%h", ok, r.ack, f, r.rdata, r.err, exp_rd);
    end
    ref_ptr = 2;
  endtask

  initial begin : watchdog
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    errors++;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $fatal(1, "watchdog expired");
  end

  initial begin : main
    for (int i = 0; i < 256; i++) begin
      slv_mem[i] = 16'($urandom());
      ref_mem[i] = slv_mem[i];
    end
    test_reset();
    test_single_write();
    test_single_read();
    test_contention();
    test_fairness();
    test_random();
    test_timeout();
    test_reset_mid_busy();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
